// File: rtl/ram_split_pkg.sv
// Shared types and helpers for the Ram_if address splitter family.
// Contents:
//   split_state_t : response-tracking FSM states
//   decode_idx    : extracts the leaf-select bit-field from an address
package ram_split_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RESP,
        ST_WAIT,
        ST_ABORT
    } split_state_t;

    // Returns addr[lsb +: w], zero-extended to 32 bits.
    function automatic logic [31:0] decode_idx(input logic [31:0] addr,
                                               input int unsigned lsb,
                                               input int unsigned w);
        return (addr >> lsb) & ((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/ram_if_split_n_if.sv
// Ram_if bus: single-cycle request with a memory-driven stall (delay).
// Signals:
//   en, we, addr, data_w, be : request, driven by the requester
//   data_r, delay            : response, driven by the memory
// Modports:
//   master : requester side (drives the request)
//   slave  : memory side (drives the response)
interface ram_if_split_n_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                en;
    logic                we;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   data_w;
    logic [DATA_W/8-1:0] be;
    logic [DATA_W-1:0]   data_r;
    logic                delay;

    modport master (output en, we, addr, data_w, be, input data_r, delay);
    modport slave  (input en, we, addr, data_w, be, output data_r, delay);
endinterface

// File: rtl/ram_split_timeout.sv
// Saturating stall counter with terminal-count compare.
// Ports:
//   clk, reset : clock, synchronous active-low reset
//   i_start    : load the count with 1 (first stall cycle seen)
//   i_en       : increment, saturating at all-ones
//   o_expired  : count has reached TIMEOUT (never set when TIMEOUT == 0)
module ram_split_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic i_start,
    input  logic i_en,
    output logic o_expired
);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_start) begin
            r_cnt <= CNT_W'(1);
        end else if (i_en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT));
endmodule

// File: rtl/ram_if_split_n.sv
// N-way Ram_if address splitter: one requester fanned out to N_OUT leaves,
// selected by addr[SEL_LSB +: SEL_W]. Responses are muxed back on the
// selection registered at accept time. Unmapped or dead leaves answer with
// ERR_DATA; a leaf stalling beyond TIMEOUT cycles is aborted and marked dead.
// Ports:
//   clk, reset  : clock, synchronous active-low reset
//   top         : request from the master, response back
//   out[N_OUT]  : leaf requests, leaf responses
//   decode_err  : 1-cycle pulse in the response cycle of an unmapped access
//   timeout_err : 1-cycle pulse when a stalled access is aborted
//   dead_mask   : sticky per-leaf timeout flags, cleared only by reset
//
// state    | meaning
// ST_IDLE  | no response owed
// ST_RESP  | response cycle of the last accepted access
// ST_WAIT  | leaf is stalling, counting stall cycles
// ST_ABORT | stall exceeded TIMEOUT, error response returned
module ram_if_split_n
    import ram_split_pkg::*;
#(
    parameter int                N_OUT    = 4,
    parameter int                SEL_LSB  = 28,
    parameter int                SEL_W    = $clog2(N_OUT),
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] ERR_DATA = 32'hdead_beef,
    parameter int                TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              reset,
    ram_if_split_n_if.slave   top,
    ram_if_split_n_if.master  out [N_OUT],
    output logic              decode_err,
    output logic              timeout_err,
    output logic [N_OUT-1:0]  dead_mask
);
    // Leaf-indexed arrays are padded to the full select range so that an
    // out-of-range select reads harmless zeros instead of indexing past N_OUT.
    localparam int              NSEL   = 1 << SEL_W;
    localparam logic [NSEL-1:0] MAPPED = {NSEL{1'b1}} >> (NSEL - N_OUT);

    split_state_t      r_state;
    split_state_t      w_state_nxt;
    logic [SEL_W-1:0]  r_sel_d;
    logic              r_err_d;
    logic [N_OUT-1:0]  r_dead;

    logic [SEL_W-1:0]  w_idx;
    logic [NSEL-1:0]   w_live;
    logic              w_unmapped;
    logic              w_accept;
    logic [DATA_W-1:0] w_leaf_data [NSEL];
    logic [NSEL-1:0]   w_leaf_delay;
    logic [DATA_W-1:0] w_sel_data;
    logic              w_sel_delay;
    logic [DATA_W-1:0] w_resp_data;
    logic              w_resp_delay;
    logic              w_cnt_start;
    logic              w_cnt_en;
    logic              w_expired;

    assign w_idx      = SEL_W'(decode_idx(top.addr, SEL_LSB, SEL_W));
    assign w_live     = MAPPED & ~NSEL'(r_dead);
    assign w_unmapped = !w_live[w_idx];

    for (genvar g = 0; g < NSEL; g++) begin : g_leaf
        if (g < N_OUT) begin : g_live
            assign out[g].en     = reset && top.en && !w_unmapped && (w_idx == SEL_W'(g));
            assign out[g].we     = reset && top.we && !w_unmapped && (w_idx == SEL_W'(g));
            assign out[g].addr   = top.addr;
            assign out[g].data_w = top.data_w;
            assign out[g].be     = top.be;
            assign w_leaf_data[g]  = out[g].data_r;
            assign w_leaf_delay[g] = out[g].delay;
        end else begin : g_pad
            assign w_leaf_data[g]  = '0;
            assign w_leaf_delay[g] = 1'b0;
        end
    end

    assign w_sel_data  = w_leaf_data[r_sel_d];
    assign w_sel_delay = w_leaf_delay[r_sel_d];

    always_comb begin
        w_resp_data  = w_sel_data;
        w_resp_delay = 1'b0;
        case (r_state)
            ST_RESP: begin
                if (r_err_d) begin
                    w_resp_data = ERR_DATA;
                end else begin
                    w_resp_delay = w_sel_delay;
                end
            end
            ST_WAIT:  w_resp_delay = w_sel_delay;
            ST_ABORT: w_resp_data  = ERR_DATA;
            default:  ;
        endcase
        if (!reset) begin
            w_resp_delay = 1'b0;
        end
    end

    assign top.data_r = w_resp_data;
    assign top.delay  = w_resp_delay;
    assign w_accept   = top.en && !w_resp_delay;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_start = 1'b0;
        w_cnt_en    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (!r_err_d && w_sel_delay) begin
                    w_state_nxt = ST_WAIT;
                    w_cnt_start = 1'b1;
                end else begin
                    w_state_nxt = w_accept ? ST_RESP : ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (w_sel_delay) begin
                    w_cnt_en = 1'b1;
                    if (w_expired) w_state_nxt = ST_ABORT;
                end else begin
                    w_state_nxt = w_accept ? ST_RESP : ST_IDLE;
                end
            end
            ST_ABORT: begin
                w_state_nxt = w_accept ? ST_RESP : ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_sel_d <= '0;
            r_err_d <= 1'b0;
            r_dead  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_sel_d <= w_idx;
                r_err_d <= w_unmapped;
            end
            if (r_state == ST_ABORT) begin
                r_dead <= r_dead | N_OUT'(NSEL'(1) << r_sel_d);
            end
        end
    end

    ram_split_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .i_start   (w_cnt_start),
        .i_en      (w_cnt_en),
        .o_expired (w_expired)
    );

    assign decode_err  = reset && (r_state == ST_RESP) && r_err_d;
    assign timeout_err = reset && (r_state == ST_ABORT);
    assign dead_mask   = r_dead;
endmodule
